// File: rtl/window_pkg.sv
// Shared types and constants for the conv-datapath window generator.
`ifndef WINDOW_PKG_SV
`define WINDOW_PKG_SV

// Window payload for a given edge/channel count: [row][col][ch].
`define WINDOW_WIN_T(K_, C_) int8_t [0:(K_)-1][0:(K_)-1][0:(C_)-1]

package window_pkg;

  typedef logic signed [7:0] int8_t;

  localparam int unsigned MAX_K = 8;
  localparam int unsigned MAX_C = 8;

  // Largest window any configuration can produce.
  typedef int8_t [0:MAX_C-1] pix_max_t;
  typedef pix_max_t [0:MAX_K-1][0:MAX_K-1] win_t;

  // Advance a stride phase counter, wrapping at the stride.
  function automatic logic phase_step(input logic ph, input int unsigned stride);
    return (ph == 1'(stride - 1)) ? 1'b0 : 1'b1;
  endfunction

endpackage

`endif

// File: rtl/line_buffer_bank.sv
// K-1 column-addressed line buffers; a write shifts the addressed column up one row.
module line_buffer_bank
  import window_pkg::*;
#(
  parameter int unsigned IMG_W = 96,
  parameter int unsigned C     = 1,
  parameter int unsigned ROWS  = 3,
  parameter int unsigned COL_W = 7
) (
  input  logic                             clk,
  input  logic                             we_i,
  input  logic [COL_W-1:0]                 col_i,
  input  int8_t [0:C-1]                    din_i,
  output int8_t [0:ROWS-1][0:C-1]          rd_c_o
);

  typedef int8_t [0:C-1] pix_t;

  pix_t mem_q [ROWS][IMG_W];

  // Read the addressed column before it is updated; rd_c_o[k] is k+1 rows above.
  always_comb begin
    for (int k = 0; k < ROWS; k++) begin
      rd_c_o[k] = mem_q[k][col_i];
    end
  end

  // Column shift: newest pixel enters row 0, older rows move up.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[0][col_i] <= din_i;
      for (int k = 1; k < ROWS; k++) begin
        mem_q[k][col_i] <= mem_q[k-1][col_i];
      end
    end
  end

endmodule

// File: rtl/window_gen.sv
// Streaming KxKxC window generator with ready/valid handshake and end-of-frame flag.
module window_gen
  import window_pkg::*;
#(
  parameter int unsigned IMG_W  = 96,
  parameter int unsigned IMG_H  = 96,
  parameter int unsigned K      = 4,
  parameter int unsigned C      = 1,
  parameter int unsigned STRIDE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  int8_t [0:C-1]        pixel_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output `WINDOW_WIN_T(K, C)   win_out,
  output logic                 out_last
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  if (K < 2 || K > MAX_K || C < 1 || C > MAX_C || !(STRIDE == 1 || STRIDE == 2) ||
      IMG_W < K || IMG_H < K ||
      ((IMG_W - K) % STRIDE) != 0 || ((IMG_H - K) % STRIDE) != 0) begin : g_bad_params
    $error("window_gen: illegal parameter combination");
  end

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   cph_q, cph_d;
  logic                   rph_q, rph_d;
  logic                   out_valid_q, out_valid_d;
  logic                   last_q, last_d;
  `WINDOW_WIN_T(K, C)     win_q, win_d;
  `WINDOW_WIN_T(K, C)     sr_q, sr_d;
  int8_t [0:K-2][0:C-1]   lb_rd;

  logic acc;
  logic col_wrap;
  logic row_wrap;
  logic fire;
  logic last_px;

  assign in_ready  = !out_valid_q || out_ready;
  assign acc       = in_valid && in_ready;
  assign col_wrap  = (col_q == CW'(IMG_W - 1));
  assign row_wrap  = (row_q == RW'(IMG_H - 1));
  assign fire      = acc && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1)) && !cph_q && !rph_q;
  assign last_px   = row_wrap && col_wrap;

  assign out_valid = out_valid_q;
  assign out_last  = last_q;
  assign win_out   = win_q;

  line_buffer_bank #(
    .IMG_W (IMG_W),
    .C     (C),
    .ROWS  (K - 1),
    .COL_W (CW)
  ) u_lb (
    .clk    (clk),
    .we_i   (acc),
    .col_i  (col_q),
    .din_i  (pixel_in),
    .rd_c_o (lb_rd)
  );

  // Raster position and stride phases; phases start at K-1 and reset on wrap.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cph_d = cph_q;
    rph_d = rph_q;
    if (acc) begin
      if (col_wrap) begin
        col_d = '0;
        cph_d = 1'b0;
        if (row_wrap) begin
          row_d = '0;
          rph_d = 1'b0;
        end else begin
          row_d = row_q + RW'(1);
          if (row_q >= RW'(K - 1)) begin
            rph_d = phase_step(rph_q, STRIDE);
          end
        end
      end else begin
        col_d = col_q + CW'(1);
        if (col_q >= CW'(K - 1)) begin
          cph_d = phase_step(cph_q, STRIDE);
        end
      end
    end
  end

  // Row shift registers: bottom row takes the new pixel, row i takes the pixel K-1-i rows up.
  always_comb begin
    sr_d = sr_q;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        sr_d[i][j] = sr_q[i][j+1];
      end
    end
    for (int i = 0; i < K - 1; i++) begin
      sr_d[i][K-1] = lb_rd[K-2-i];
    end
    sr_d[K-1][K-1] = pixel_in;
  end

  // Single-entry output register: load on a completed window, clear on pop, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    last_d      = last_q;
    win_d       = win_q;
    if (fire) begin
      out_valid_d = 1'b1;
      last_d      = last_px;
      win_d       = sr_d;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      last_d      = 1'b0;
    end
  end

  // Control and output state.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      cph_q       <= 1'b0;
      rph_q       <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      win_q       <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      cph_q       <= cph_d;
      rph_q       <= rph_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      win_q       <= win_d;
    end
  end

  // Window shift registers carry no reset; stale columns are flushed before use.
  always_ff @(posedge clk) begin
    if (acc) begin
      sr_q <= sr_d;
    end
  end

endmodule
